// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between the pipeline, mem_arbiter and the RAM.
//   Pipeline side : iREN/iaddr, dREN/dWEN/daddr/dstore in; ihit/iload, dhit/dload, err out
//   RAM side      : ramREN/ramWEN/ramaddr/ramstore out; ramload/ramstate in
//   Perf counters : perf_dstall/perf_istall (zero unless MEM_ARBITER_PERF_EN is defined)
// slave  : the arbiter's view (it responds to the pipeline and drives the RAM strobes).
// master : the environment's view (pipeline + RAM model).
interface mem_arbiter_if;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 2;

    logic                iREN;
    logic [WORD_W-1:0]   iaddr;
    logic                dREN;
    logic                dWEN;
    logic [WORD_W-1:0]   daddr;
    logic [WORD_W-1:0]   dstore;
    logic                ihit;
    logic [WORD_W-1:0]   iload;
    logic                dhit;
    logic [WORD_W-1:0]   dload;
    logic                err;
    logic                ramREN;
    logic                ramWEN;
    logic [WORD_W-1:0]   ramaddr;
    logic [WORD_W-1:0]   ramstore;
    logic [WORD_W-1:0]   ramload;
    logic [STATE_W-1:0]  ramstate;
    logic [WORD_W-1:0]   perf_dstall;
    logic [WORD_W-1:0]   perf_istall;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, err,
               ramREN, ramWEN, ramaddr, ramstore, perf_dstall, perf_istall
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, err,
               ramREN, ramWEN, ramaddr, ramstore, perf_dstall, perf_istall
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data-memory requests onto one
// single-ported RAM and returns one-cycle ihit/dhit pulses with load data.
// Ports:
//   CLK   - system clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - mem_arbiter_if.slave (pipeline requests/responses, RAM strobes, perf counters)
// Parameters:
//   TIMEOUT  - REQ cycles without ACCESS before an error response (1..255)
//   ERR_WORD - load value returned with err
// Optional feature: define MEM_ARBITER_PERF_EN to enable the stall counters
// perf_dstall/perf_istall; otherwise both read as zero.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hBAD1_BAD1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DREQ  = 3'd1,
        IREQ  = 3'd2,
        DRESP = 3'd3,
        IRESP = 3'd4,
        ERESP = 3'd5
    } state_t;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    state_t              state_q, state_d;
    port_t               last_q, last_d;
    port_t               port_q, port_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ihit_q, ihit_d;
    logic                dhit_q, dhit_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   iload_q, iload_d;
    logic [WORD_W-1:0]   dload_q, dload_d;

    logic                ram_ren_c;
    logic                ram_wen_c;
    logic [WORD_W-1:0]   ram_addr_c;
    logic [WORD_W-1:0]   ram_store_c;

    logic d_req;
    logic i_req;
    logic ram_access;
    logic ram_error;

    assign d_req      = bus.dREN | bus.dWEN;
    assign i_req      = bus.iREN;
    assign ram_access = (bus.ramstate == RAM_ACCESS);
    assign ram_error  = (bus.ramstate == RAM_ERROR);

    // State and registered response outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            last_q  <= PORT_INSTR;
            port_q  <= PORT_INSTR;
            cnt_q   <= '0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            err_q   <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            err_q   <= err_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    // Next-state, response capture and RAM strobes (strobes decode the current state)
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        err_d       = 1'b0;
        iload_d     = iload_q;
        dload_d     = dload_q;
        ram_ren_c   = 1'b0;
        ram_wen_c   = 1'b0;
        ram_addr_c  = '0;
        ram_store_c = '0;

        case (state_q)
            IDLE: begin
                // Data wins a tie unless it was served last, so neither port starves
                if (d_req && (!i_req || (last_q != PORT_DATA))) begin
                    state_d = DREQ;
                    port_d  = PORT_DATA;
                    cnt_d   = '0;
                end else if (i_req) begin
                    state_d = IREQ;
                    port_d  = PORT_INSTR;
                    cnt_d   = '0;
                end
            end

            DREQ: begin
                if (!d_req) begin
                    // Withdrawn: strobes stay low this cycle, no hit
                    state_d = IDLE;
                end else begin
                    // dREN together with dWEN is treated as a write
                    ram_addr_c  = bus.daddr;
                    ram_store_c = bus.dstore;
                    ram_wen_c   = bus.dWEN;
                    ram_ren_c   = bus.dREN & ~bus.dWEN;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (ram_access) begin
                        if (!bus.dWEN) begin
                            dload_d = bus.ramload;
                        end
                        dhit_d  = 1'b1;
                        state_d = DRESP;
                    end else if (ram_error || (cnt_d == TIMEOUT_CNT)) begin
                        dload_d = ERR_WORD;
                        dhit_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = ERESP;
                    end
                end
            end

            IREQ: begin
                if (!i_req) begin
                    state_d = IDLE;
                end else begin
                    ram_addr_c = bus.iaddr;
                    ram_ren_c  = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (ram_access) begin
                        iload_d = bus.ramload;
                        ihit_d  = 1'b1;
                        state_d = IRESP;
                    end else if (ram_error || (cnt_d == TIMEOUT_CNT)) begin
                        iload_d = ERR_WORD;
                        ihit_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = ERESP;
                    end
                end
            end

            DRESP: begin
                last_d  = PORT_DATA;
                state_d = IDLE;
            end

            IRESP: begin
                last_d  = PORT_INSTR;
                state_d = IDLE;
            end

            ERESP: begin
                // An error response still counts as serving that port
                last_d  = port_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ihit     = ihit_q;
    assign bus.iload    = iload_q;
    assign bus.dhit     = dhit_q;
    assign bus.dload    = dload_q;
    assign bus.err      = err_q;
    assign bus.ramREN   = ram_ren_c;
    assign bus.ramWEN   = ram_wen_c;
    assign bus.ramaddr  = ram_addr_c;
    assign bus.ramstore = ram_store_c;

`ifdef MEM_ARBITER_PERF_EN
    logic [WORD_W-1:0] perf_dstall_q;
    logic [WORD_W-1:0] perf_istall_q;

    // Saturating stall counters: request pending but no hit this cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_dstall_q <= '0;
            perf_istall_q <= '0;
        end else begin
            if (d_req && !dhit_q && (perf_dstall_q != {WORD_W{1'b1}})) begin
                perf_dstall_q <= perf_dstall_q + WORD_W'(1);
            end
            if (i_req && !ihit_q && (perf_istall_q != {WORD_W{1'b1}})) begin
                perf_istall_q <= perf_istall_q + WORD_W'(1);
            end
        end
    end

    assign bus.perf_dstall = perf_dstall_q;
    assign bus.perf_istall = perf_istall_q;
`else
    assign bus.perf_dstall = '0;
    assign bus.perf_istall = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (TIMEOUT=4) with a
// latency-programmable RAM model.
module tb_mem_arbiter;
    logic clk;
    logic nrst;

    mem_arbiter_if bus();

    mem_arbiter #(
        .TIMEOUT  (4),
        .ERR_WORD (32'hBAD1_BAD1)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: ACCESS after ram_lat BUSY cycles, or ERROR while ram_err is set
    int          ram_lat;
    logic        ram_err;
    logic [7:0]  rcnt;
    logic [31:0] mem [256];
    logic [255:0] written = '0;
    logic [7:0]  ram_idx;

    function automatic logic [31:0] rom_word(input logic [7:0] idx);
        case (idx)
            8'd16:   return 32'h8C22_0004;
            8'd17:   return 32'h1234_5678;
            8'd192:  return 32'hA5A5_0001;
            default: return {24'hC0FFEE, idx};
        endcase
    endfunction

    assign ram_idx      = bus.ramaddr[9:2];
    assign bus.ramstate = !(bus.ramREN | bus.ramWEN) ? 2'd0 :
                          ram_err                    ? 2'd3 :
                          (int'(rcnt) == ram_lat)    ? 2'd2 : 2'd1;
    assign bus.ramload  = written[ram_idx] ? mem[ram_idx] : rom_word(ram_idx);

    always @(posedge clk) begin
        if (!(bus.ramREN | bus.ramWEN) || (bus.ramstate == 2'd2)) rcnt <= 8'd0;
        else rcnt <= rcnt + 8'd1;
        if (bus.ramWEN && (bus.ramstate == 2'd2)) begin
            mem[ram_idx]     <= bus.ramstore;
            written[ram_idx] <= 1'b1;
        end
    end

    typedef struct {
        logic        port;   // 1 = data, 0 = instruction
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   hit_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Counts negedges until a hit is visible, bounded by budget
    task automatic wait_hit(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.ihit || bus.dhit) && (n < budget));
    endtask

    // Monitor: every hit pops one expected response
    initial begin
        exp_t e;
        hit_count = 0;
        forever begin
            @(negedge clk);
            if (nrst && (bus.ihit || bus.dhit)) begin
                hit_count++;
                chk("hit_exclusive", 32'(bus.ihit & bus.dhit), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit: ihit=%0b dhit=%0b with empty scoreboard",
                             bus.ihit, bus.dhit);
                end else begin
                    e = sb.pop_front();
                    chk("sb_port", 32'(bus.dhit), 32'(e.port));
                    chk("sb_data", bus.dhit ? bus.dload : bus.iload, e.data);
                    chk("sb_err", 32'(bus.err), 32'(e.err));
                end
            end
        end
    end

    task automatic drop_all();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    initial begin
        int n;
        int hits_before;
        logic ren_seen;

        checks = 0;
        errors = 0;
        nrst = 1'b0;
        ram_lat = 0;
        ram_err = 1'b0;
        drop_all();
        bus.iaddr  = '0;
        bus.daddr  = '0;
        bus.dstore = '0;

        // Reset state
        #12;
        chk("rst_ihit", 32'(bus.ihit), 32'd0);
        chk("rst_dhit", 32'(bus.dhit), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_iload", bus.iload, 32'd0);
        chk("rst_dload", bus.dload, 32'd0);
        chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_perf_d", bus.perf_dstall, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Instruction read, two BUSY cycles before ACCESS
        ram_lat = 2;
        bus.iaddr = 32'h40;
        bus.iREN = 1'b1;
        push(1'b0, 32'h8C22_0004, 1'b0);
        wait_hit(30, n);
        chk("iread_latency", 32'(n), 32'd4);
        drop_all();
        repeat (2) @(negedge clk);

        // Data read with immediate ACCESS: minimum latency
        ram_lat = 0;
        bus.daddr = 32'h300;
        bus.dREN = 1'b1;
        push(1'b1, 32'hA5A5_0001, 1'b0);
        wait_hit(30, n);
        chk("dread_latency", 32'(n), 32'd2);
        drop_all();
        repeat (2) @(negedge clk);

        // Data write: dload keeps the previous read value
        ram_lat = 2;
        bus.daddr  = 32'h100;
        bus.dstore = 32'hDEAD_BEEF;
        bus.dWEN   = 1'b1;
        push(1'b1, 32'hA5A5_0001, 1'b0);
        n = 0;
        ren_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (bus.ramREN) ren_seen = 1'b1;
            if (n == 2) begin
                chk("wr_ramWEN", 32'(bus.ramWEN), 32'd1);
                chk("wr_ramaddr", bus.ramaddr, 32'h100);
                chk("wr_ramstore", bus.ramstore, 32'hDEAD_BEEF);
            end
        end while (!bus.dhit && (n < 30));
        chk("wr_latency", 32'(n), 32'd4);
        chk("wr_ramREN_never", 32'(ren_seen), 32'd0);
        chk("wr_resp_ramWEN", 32'(bus.ramWEN), 32'd0);
        drop_all();
        repeat (2) @(negedge clk);

        // Simultaneous requests from reset: data first, then alternate
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        ram_lat = 1;
        bus.iaddr = 32'h44;
        bus.daddr = 32'h100;
        bus.dREN  = 1'b1;
        bus.iREN  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(1'b1, 32'hDEAD_BEEF, 1'b0);
            push(1'b0, 32'h1234_5678, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            wait_hit(30, n);
            chk("alt_latency", 32'(n), (k == 0) ? 32'd3 : 32'd4);
        end
        drop_all();
        repeat (2) @(negedge clk);

        // Timeout: RAM stays BUSY for TIMEOUT=4 REQ cycles
        ram_lat = 255;
        bus.daddr = 32'h200;
        bus.dREN = 1'b1;
        push(1'b1, 32'hBAD1_BAD1, 1'b1);
        wait_hit(30, n);
        chk("timeout_latency", 32'(n), 32'd5);
        drop_all();
        repeat (2) @(negedge clk);
        chk("err_cleared", 32'(bus.err), 32'd0);

        // RAM ERROR on an instruction fetch
        ram_err = 1'b1;
        bus.iaddr = 32'h40;
        bus.iREN = 1'b1;
        push(1'b0, 32'hBAD1_BAD1, 1'b1);
        wait_hit(30, n);
        chk("ramerr_latency", 32'(n), 32'd2);
        drop_all();
        ram_err = 1'b0;
        repeat (2) @(negedge clk);

        // Withdrawal in IREQ: strobe drops the same cycle, no hit
        ram_lat = 255;
        hits_before = hit_count;
        bus.iREN = 1'b1;
        repeat (2) @(negedge clk);
        chk("wd_ramREN_before", 32'(bus.ramREN), 32'd1);
        bus.iREN = 1'b0;
        #1;
        chk("wd_ramREN_after", 32'(bus.ramREN), 32'd0);
        repeat (8) @(negedge clk);
        chk("wd_no_hit", 32'(hit_count), 32'(hits_before));

        // Reset asserted mid-IREQ
        bus.iREN = 1'b1;
        repeat (2) @(negedge clk);
        chk("rm_ramREN_before", 32'(bus.ramREN), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("rm_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rm_ramaddr", bus.ramaddr, 32'd0);
        chk("rm_iload", bus.iload, 32'd0);
        chk("rm_dload", bus.dload, 32'd0);
        chk("rm_ihit", 32'(bus.ihit), 32'd0);
        bus.iREN = 1'b0;
        hits_before = hit_count;
        @(negedge clk);
        nrst = 1'b1;
        repeat (8) @(negedge clk);
        chk("rm_no_hit", 32'(hit_count), 32'(hits_before));

        // Stall counters over a data read with hit on the 5th cycle
        ram_lat = 2;
        bus.daddr = 32'h300;
        bus.dREN = 1'b1;
        push(1'b1, 32'hA5A5_0001, 1'b0);
        wait_hit(30, n);
        chk("perf_latency", 32'(n), 32'd4);
        drop_all();
        @(negedge clk);
`ifdef MEM_ARBITER_PERF_EN
        chk("perf_dstall", bus.perf_dstall, 32'd4);
`else
        chk("perf_dstall", bus.perf_dstall, 32'd0);
`endif
        chk("perf_istall", bus.perf_istall, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder that generates the ihit/dhit pair consumed by the hazard unit.
- Arbitrates the instruction-fetch port and the data-memory port onto a single-ported RAM.
- Returns one-cycle hit pulses with load data.
- Sits between the pipeline datapath (IF stage and MEM stage requests) and the RAM model. The hazard unit stalls or advances pipeline registers on these pulses.

Parameters:
- TIMEOUT, 255: max cycles a request waits for RAM ACCESS before an error response; 8-bit counter, legal range 1..255.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an error response.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous, active-low reset
- iREN  input  1  instruction read request, held until ihit
- iaddr  input  32  instruction word address
- dREN  input  1  data read request, held until dhit
- dWEN  input  1  data write request, held until dhit
- daddr  input  32  data address
- dstore  input  32  data write value
- ihit  output  1  one-cycle pulse: instruction response valid
- iload  output  32  instruction word, valid while ihit=1
- dhit  output  1  one-cycle pulse: data response valid
- dload  output  32  data read word, valid while dhit=1
- err  output  1  one-cycle pulse coincident with the erroring hit
- ramREN  output  1  RAM read strobe
- ramWEN  output  1  RAM write strobe
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data, valid when ramstate=ACCESS
- ramstate  input  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- perf_dstall  output  32  data-stall cycle count (optional feature)
- perf_istall  output  32  instruction-stall cycle count (optional feature)

Behaviour:
- Clock and reset: one clock CLK; nRST is asynchronous, active-low.
- Reset values:
  - All outputs 0 (iload/dload 0).
  - State IDLE; last_served = INSTR; timeout counter 0.
- States: IDLE, DREQ, IREQ, DRESP, IRESP, ERESP.
- IDLE arbitration:
  - dREN|dWEN and iREN both pending: choose data unless last_served=DATA, then instruction (alternation; no starvation).
  - Only one pending: serve it.
  - dREN and dWEN both high is illegal; treated as write.
- DREQ:
  - Drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN, combinationally from state.
  - ramstate=ACCESS: register dload<=ramload (reads only; writes leave dload unchanged), go DRESP.
- IREQ:
  - Drive ramaddr=iaddr, ramREN=1.
  - ACCESS: register iload<=ramload, go IRESP.
- DRESP / IRESP:
  - dhit (resp. ihit)=1 for exactly one cycle.
  - last_served updated.
  - Next state IDLE; the next request is accepted the following cycle.
  - Minimum latency: request seen in IDLE at cycle N, hit at N+2 when ACCESS arrives in N+1.
- Errors:
  - In DREQ/IREQ, ramstate=ERROR, or counter reaching TIMEOUT without ACCESS: go ERESP.
  - ERESP pulses the hit of the pending port with load=ERR_WORD and err=1, then IDLE.
  - Counter clears on entry to any REQ state and increments each REQ cycle without ACCESS.
- Request withdrawn while in REQ (requesting port's enable falls): drop RAM strobes the same cycle, return to IDLE next edge. No hit, last_served unchanged.
- ram strobes are 0 in all states except DREQ/IREQ.
- ihit and dhit are never high in the same cycle.
- Reset asserted mid-transfer: immediately IDLE, strobes low, no hit is emitted after release.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined:
  - perf_dstall increments each cycle (dREN|dWEN)=1 and dhit=0.
  - perf_istall increments each cycle iREN=1 and ihit=0.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on nRST.
- Undefined: both ports tied to 0, no counter logic.

Test Plan:
- Instruction read only: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0x8C220004 -> single ihit pulse, iload=0x8C220004, dhit=0, err=0.
- Data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF until ACCESS; one dhit pulse; ramREN never high.
- Simultaneous requests, held high: iREN=dREN=1, RAM ACCESS every 2nd cycle -> data served first, then instruction, then data alternating; ihit and dhit never coincide.
- Timeout with TIMEOUT=4: dREN=1, ramstate held BUSY -> dhit with dload=0xBAD1BAD1 and err=1 after 4 REQ cycles.
- Reset mid-transfer: nRST low while in IREQ -> ramREN drops asynchronously, all outputs 0; after release with iREN=0, no ihit.
- MEM_ARBITER_PERF_EN defined: dREN held for a 5-cycle transfer (hit on 5th) -> perf_dstall=4, perf_istall=0.
